id_ex_ctrl_pipe: RTL and testbench



---
 rtl/ctrl_pkg.sv | 82 ++++++++
 rtl/ctrl_decode.sv | 62 ++++++
 rtl/id_ex_ctrl_pipe.sv | 125 ++++++++++++
 tb/tb_id_ex_ctrl_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and the ID/EX control bundle for the ID-stage decoder and pipeline register.
package ctrl_pkg;

  localparam int ALU_CODE_W = 4;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SRL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_XOR = 4'd9;
  localparam logic [3:0] ALU_SLL = 4'd10;
  localparam logic [3:0] ALU_SRA = 4'd11;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] WB_REG = 2'b10;
  localparam logic [1:0] WB_MEM = 2'b11;
  localparam logic [1:0] M_RD   = 2'b10;
  localparam logic [1:0] M_WR   = 2'b01;

  localparam logic [3:0] JF_J    = 4'b1000;
  localparam logic [3:0] JF_JAL  = 4'b0100;
  localparam logic [3:0] JF_JR   = 4'b0010;
  localparam logic [3:0] JF_JALR = 4'b0001;

  localparam logic [1:0] HILO_HI = 2'b10;
  localparam logic [1:0] HILO_LO = 2'b01;

  // ex = {RegDst, ALUSrc, ALUControl}; widened to ALUOP_W at the pipeline output.
  typedef struct packed {
    logic [1:0] wb;
    logic [1:0] m;
    logic [5:0] ex;
    logic       beq;
    logic       bne;
    logic [3:0] jfamily;
    logic       shift;
    logic       valid;
    logic [1:0] md_hilo;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder producing the ID/EX control bundle and mul/div issue info.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output ctrl_bundle_t ctrl,
  output logic         is_md,
  output logic [1:0]   md_op,
  output logic         illegal
);

  always_comb begin
    ctrl    = BUBBLE;
    is_md   = 1'b0;
    md_op   = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.valid = 1'b1;
        ctrl.ex    = {2'b10, ALU_AND};
        case (funct)
          FN_ADD:  begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_ADD; end
          FN_SUB:  begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_SUB; end
          FN_AND:  begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_AND; end
          FN_OR:   begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_OR;  end
          FN_XOR:  begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_XOR; end
          FN_NOR:  begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_NOR; end
          FN_SLT:  begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_SLT; end
          FN_SLL:  begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_SLL; ctrl.shift = 1'b1; end
          FN_SRL:  begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_SRL; ctrl.shift = 1'b1; end
          FN_SRA:  begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_SRA; ctrl.shift = 1'b1; end
          FN_JR:   begin ctrl.ex[3:0] = ALU_ADD; ctrl.jfamily = JF_JR; end
          FN_JALR: begin ctrl.wb = WB_REG; ctrl.ex[3:0] = ALU_ADD; ctrl.jfamily = JF_JALR; end
          FN_MFHI: begin ctrl.wb = WB_REG; ctrl.md_hilo = HILO_HI; end
          FN_MFLO: begin ctrl.wb = WB_REG; ctrl.md_hilo = HILO_LO; end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            is_md = 1'b1;
            md_op = funct[1:0];
          end
          default: begin
            ctrl    = BUBBLE;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: ctrl = '{wb: WB_REG, m: 2'b00, ex: {2'b01, ALU_ADD}, valid: 1'b1, default: '0};
      OP_ANDI: ctrl = '{wb: WB_REG, m: 2'b00, ex: {2'b01, ALU_AND}, valid: 1'b1, default: '0};
      OP_ORI:  ctrl = '{wb: WB_REG, m: 2'b00, ex: {2'b01, ALU_OR},  valid: 1'b1, default: '0};
      OP_XORI: ctrl = '{wb: WB_REG, m: 2'b00, ex: {2'b01, ALU_XOR}, valid: 1'b1, default: '0};
      OP_SLTI: ctrl = '{wb: WB_REG, m: 2'b00, ex: {2'b01, ALU_SLT}, valid: 1'b1, default: '0};
      OP_LW:   ctrl = '{wb: WB_MEM, m: M_RD,  ex: {2'b01, ALU_ADD}, valid: 1'b1, default: '0};
      OP_SW:   ctrl = '{wb: 2'b00,  m: M_WR,  ex: {2'b01, ALU_ADD}, valid: 1'b1, default: '0};
      OP_BEQ:  ctrl = '{ex: {2'b00, ALU_SUB}, beq: 1'b1, valid: 1'b1, default: '0};
      OP_BNE:  ctrl = '{ex: {2'b00, ALU_SUB}, bne: 1'b1, valid: 1'b1, default: '0};
      OP_J:    ctrl = '{jfamily: JF_J, valid: 1'b1, default: '0};
      OP_JAL:  ctrl = '{wb: WB_REG, jfamily: JF_JAL, valid: 1'b1, default: '0};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control pipeline register with mul/div issue tracking, busy counter and structural-hazard stall.
module id_ex_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               stall_in,
  input  logic               flush_in,
  output logic [1:0]         ex_wb,
  output logic [1:0]         ex_m,
  output logic [ALUOP_W+1:0] ex_ex,
  output logic               ex_beq,
  output logic               ex_bne,
  output logic               ex_shift,
  output logic [3:0]         ex_jfamily,
  output logic               ex_valid,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic [1:0]         md_hilo,
  output logic               md_busy,
  output logic               stall_out,
  output logic               illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  ctrl_bundle_t dec_ctrl;
  logic         dec_is_md;
  logic [1:0]   dec_md_op;
  logic         dec_illegal;

  ctrl_bundle_t bundle_q, bundle_d;
  logic         md_start_q, md_start_d;
  logic [1:0]   md_op_q, md_op_d;
  logic         illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         busy;
  logic         hazard;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .ctrl    (dec_ctrl),
    .is_md   (dec_is_md),
    .md_op   (dec_md_op),
    .illegal (dec_illegal)
  );

  always_comb begin
    busy      = (cnt_q != '0);
    hazard    = instr_valid & busy & (dec_is_md | (dec_ctrl.md_hilo != 2'b00));
    stall_out = hazard & ~flush_in;

    bundle_d   = bundle_q;
    md_start_d = 1'b0;
    md_op_d    = md_op_q;
    illegal_d  = 1'b0;

    // A held mul/div keeps its bundle but never re-pulses md_start.
    if (flush_in) begin
      bundle_d = BUBBLE;
      md_op_d  = '0;
    end else if (stall_in) begin
      bundle_d = bundle_q;
    end else if (hazard) begin
      bundle_d = BUBBLE;
      md_op_d  = '0;
    end else if (instr_valid & ~dec_illegal) begin
      bundle_d   = dec_ctrl;
      md_start_d = dec_is_md;
      md_op_d    = dec_is_md ? dec_md_op : 2'b00;
    end else begin
      bundle_d  = BUBBLE;
      md_op_d   = '0;
      illegal_d = instr_valid & dec_illegal;
    end

    if (md_start_d) begin
      cnt_d = dec_md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bundle_q   <= BUBBLE;
      md_start_q <= 1'b0;
      md_op_q    <= '0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bundle_q   <= bundle_d;
      md_start_q <= md_start_d;
      md_op_q    <= md_op_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_wb      = bundle_q.wb;
  assign ex_m       = bundle_q.m;
  assign ex_ex      = {bundle_q.ex[5:4], ALUOP_W'(bundle_q.ex[3:0])};
  assign ex_beq     = bundle_q.beq;
  assign ex_bne     = bundle_q.bne;
  assign ex_shift   = bundle_q.shift;
  assign ex_jfamily = bundle_q.jfamily;
  assign ex_valid   = bundle_q.valid;
  assign md_start   = md_start_q;
  assign md_op      = md_op_q;
  assign md_hilo    = bundle_q.md_hilo;
  assign md_busy    = busy;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Directed bench for id_ex_ctrl_pipe: mnemonic-level reference model compared every cycle, plus literal pins.
module tb_id_ex_ctrl_pipe;

  localparam int ALUOP_W = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] J = 6'h02, JAL = 6'h03, ADDI = 6'h08, SLTI = 6'h0A;
  localparam logic [5:0] ANDI = 6'h0C, ORI = 6'h0D, XORI = 6'h0E;
  localparam logic [5:0] F_ADD = 6'h20, F_SLL = 6'h00, F_SRA = 6'h03, F_JALR = 6'h09;
  localparam logic [5:0] F_MULT = 6'h18, F_DIV = 6'h1A, F_DIVU = 6'h1B, F_MFLO = 6'h12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic stall_in = 1'b0;
  logic flush_in = 1'b0;

  logic [1:0] ex_wb, ex_m, md_op, md_hilo;
  logic [ALUOP_W+1:0] ex_ex;
  logic ex_beq, ex_bne, ex_shift, ex_valid, md_start, md_busy, stall_out, illegal;
  logic [3:0] ex_jfamily;

  always #5 clk = ~clk;

  id_ex_ctrl_pipe #(.ALUOP_W(ALUOP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .stall_in(stall_in), .flush_in(flush_in), .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_shift(ex_shift), .ex_jfamily(ex_jfamily),
    .ex_valid(ex_valid), .md_start(md_start), .md_op(md_op), .md_hilo(md_hilo),
    .md_busy(md_busy), .stall_out(stall_out), .illegal(illegal)
  );

  // kind: 0 plain, 1 mul/div issue, 2 HI/LO move
  typedef struct packed {
    logic       legal;
    logic [1:0] kind;
    logic [1:0] wb;
    logic [1:0] m;
    logic       rd;
    logic       as;
    logic [3:0] alu;
    logic       beq;
    logic       bne;
    logic [3:0] j;
    logic       sh;
    logic [1:0] hilo;
    logic [1:0] op;
  } row_t;

  function automatic string mnem(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h00: return "SLL";   6'h02: return "SRL";   6'h03: return "SRA";
        6'h08: return "JR";    6'h09: return "JALR";  6'h10: return "MFHI";
        6'h12: return "MFLO";  6'h18: return "MULT";  6'h19: return "MULTU";
        6'h1A: return "DIV";   6'h1B: return "DIVU";  6'h20: return "ADD";
        6'h22: return "SUB";   6'h24: return "AND";   6'h25: return "OR";
        6'h26: return "XOR";   6'h27: return "NOR";   6'h2A: return "SLT";
        default: return "ILL";
      endcase
    end
    case (op)
      6'h02: return "J";     6'h03: return "JAL";   6'h04: return "BEQ";
      6'h05: return "BNE";   6'h08: return "ADDI";  6'h0A: return "SLTI";
      6'h0C: return "ANDI";  6'h0D: return "ORI";   6'h0E: return "XORI";
      6'h23: return "LW";    6'h2B: return "SW";
      default: return "ILL";
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input string n);
    case (n)
      "AND": return 4'd0;   "OR":  return 4'd1;   "ADD": return 4'd2;
      "SRL": return 4'd3;   "SUB": return 4'd6;   "SLT": return 4'd7;
      "XOR": return 4'd9;   "SLL": return 4'd10;  "SRA": return 4'd11;
      "NOR": return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  function automatic row_t spec_row(input string n);
    row_t r;
    r = '0;
    r.legal = 1'b1;
    case (n)
      "ADD", "SUB", "AND", "OR", "XOR", "NOR", "SLT", "SLL", "SRL", "SRA": begin
        r.wb = 2'b10; r.rd = 1'b1; r.alu = alu_code(n);
        r.sh = (n == "SLL" || n == "SRL" || n == "SRA");
      end
      "ADDI", "ANDI", "ORI", "XORI", "SLTI": begin
        r.wb = 2'b10; r.as = 1'b1; r.alu = alu_code(n.substr(0, n.len() - 2));
      end
      "LW":    begin r.wb = 2'b11; r.m = 2'b10; r.as = 1'b1; r.alu = alu_code("ADD"); end
      "SW":    begin r.m = 2'b01; r.as = 1'b1; r.alu = alu_code("ADD"); end
      "BEQ":   begin r.alu = alu_code("SUB"); r.beq = 1'b1; end
      "BNE":   begin r.alu = alu_code("SUB"); r.bne = 1'b1; end
      "J":     r.j = 4'b1000;
      "JAL":   begin r.wb = 2'b10; r.j = 4'b0100; end
      "JR":    begin r.rd = 1'b1; r.alu = alu_code("ADD"); r.j = 4'b0010; end
      "JALR":  begin r.wb = 2'b10; r.rd = 1'b1; r.alu = alu_code("ADD"); r.j = 4'b0001; end
      "MULT":  begin r.rd = 1'b1; r.kind = 2'd1; r.op = 2'd0; end
      "MULTU": begin r.rd = 1'b1; r.kind = 2'd1; r.op = 2'd1; end
      "DIV":   begin r.rd = 1'b1; r.kind = 2'd1; r.op = 2'd2; end
      "DIVU":  begin r.rd = 1'b1; r.kind = 2'd1; r.op = 2'd3; end
      "MFHI":  begin r.wb = 2'b10; r.rd = 1'b1; r.kind = 2'd2; r.hilo = 2'b10; end
      "MFLO":  begin r.wb = 2'b10; r.rd = 1'b1; r.kind = 2'd2; r.hilo = 2'b01; end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  // Reference model: ID/EX contents plus remaining busy cycles as a plain integer.
  row_t       m_cur = '0;
  logic       m_valid = 1'b0, m_start = 1'b0, m_ill = 1'b0;
  logic [1:0] m_op = '0;
  int         busy_left = 0;
  string      m_name;
  row_t       m_row;
  logic       m_busy, m_hz;
  int         m_lat;

  always_comb begin
    m_name = mnem(opcode, funct);
    m_row  = spec_row(m_name);
    m_busy = (busy_left > 0);
    m_hz   = instr_valid && m_busy && (m_row.kind != 2'd0);
    m_lat  = (m_name == "DIV" || m_name == "DIVU") ? DIV_LAT : MUL_LAT;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur <= '0; m_valid <= 1'b0; m_start <= 1'b0; m_op <= '0; m_ill <= 1'b0;
      busy_left <= 0;
    end else begin
      m_start <= 1'b0;
      m_ill   <= 1'b0;
      if (busy_left > 0) busy_left <= busy_left - 1;
      if (flush_in || (!stall_in && m_hz)) begin
        m_cur <= '0; m_valid <= 1'b0; m_op <= '0;
      end else if (!stall_in) begin
        if (instr_valid && m_row.legal) begin
          m_cur   <= m_row;
          m_valid <= 1'b1;
          m_start <= (m_row.kind == 2'd1);
          m_op    <= (m_row.kind == 2'd1) ? m_row.op : 2'b00;
          if (m_row.kind == 2'd1) busy_left <= m_lat;
        end else begin
          m_cur <= '0; m_valid <= 1'b0; m_op <= '0;
          m_ill <= instr_valid;
        end
      end
    end
  end

  logic [25:0] dut_vec, exp_vec;
  assign dut_vec = {ex_wb, ex_m, ex_ex, ex_beq, ex_bne, ex_shift, ex_jfamily, ex_valid,
                    md_start, md_op, md_hilo, md_busy, stall_out, illegal};
  assign exp_vec = {m_cur.wb, m_cur.m, m_cur.rd, m_cur.as, m_cur.alu, m_cur.beq, m_cur.bne,
                    m_cur.sh, m_cur.j, m_valid, m_start, m_op, m_cur.hilo, m_busy,
                    m_hz && !flush_in, m_ill};

  int tests = 0;
  int fails = 0;
  int n_start = 0;
  int n_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare against the model on the falling edge, then land 1 time unit past the rising edge.
  task automatic tick();
    @(negedge clk);
    chk("cycle", 32'(dut_vec), 32'(exp_vec));
    n_start += int'(md_start);
    n_busy  += int'(md_busy);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [5:0] op, input logic [5:0] fn,
                     input logic st, input logic fl);
    instr_valid = v; opcode = op; funct = fn; stall_in = st; flush_in = fl;
    tick();
  endtask

  logic [11:0] sweep [21] = '{
    {R, 6'h00}, {R, 6'h02}, {R, 6'h03}, {R, 6'h08}, {R, 6'h09}, {R, 6'h22}, {R, 6'h24},
    {R, 6'h25}, {R, 6'h26}, {R, 6'h27}, {R, 6'h2A}, {ADDI, 6'h00}, {SLTI, 6'h00},
    {ANDI, 6'h00}, {ORI, 6'h00}, {XORI, 6'h00}, {SW, 6'h00}, {J, 6'h00}, {JAL, 6'h00},
    {BNE, 6'h00}, {R, 6'h10}
  };

  initial begin
    int n, s0, b0;
    tick();
    tick();
    chk("reset_outs", 32'(dut_vec), 0);
    rst = 1'b0;
    tick();

    cyc(1, R, F_ADD, 0, 0);
    chk("add_wb", 32'(ex_wb), 2);
    chk("add_ex", 32'(ex_ex), 'h22);
    chk("model_add_ex", 32'({m_cur.rd, m_cur.as, m_cur.alu}), 'h22);
    cyc(1, LW, 6'h00, 0, 0);
    chk("lw_wb", 32'(ex_wb), 3);
    chk("lw_m", 32'(ex_m), 2);
    cyc(1, BEQ, 6'h00, 0, 0);
    chk("beq_wb", 32'(ex_wb), 0);
    chk("beq_flag", 32'(ex_beq), 1);
    chk("beq_ex", 32'(ex_ex), 'h06);

    for (int i = 0; i < 21; i++) begin
      cyc(1, sweep[i][11:6], sweep[i][5:0], 0, 0);
    end
    cyc(1, R, F_SRA, 0, 0);
    chk("sra_ex", 32'(ex_ex), 'h2B);
    chk("sra_shift", 32'(ex_shift), 1);
    cyc(1, R, F_JALR, 0, 0);
    chk("jalr_jf", 32'(ex_jfamily), 1);
    cyc(1, ADDI, 6'h00, 0, 0);
    chk("addi_ex", 32'(ex_ex), 'h12);
    cyc(0, 6'h00, 6'h00, 0, 0);

    s0 = n_start;
    cyc(1, R, F_MULT, 0, 0);
    chk("mult_start", 32'(md_start), 1);
    chk("mult_op", 32'(md_op), 0);
    chk("mult_busy", 32'(md_busy), 1);
    instr_valid = 1'b1; opcode = R; funct = F_MFLO;
    #1;
    n = 0;
    while (stall_out && n < 20) begin
      n++;
      tick();
    end
    chk("mflo_stall_cycles", 32'(n), 4);
    tick();
    chk("mflo_hilo", 32'(md_hilo), 1);
    chk("mflo_valid", 32'(ex_valid), 1);
    chk("mult_starts", 32'(n_start - s0), 1);
    cyc(0, 6'h00, 6'h00, 0, 0);

    s0 = n_start;
    b0 = n_busy;
    cyc(1, R, F_DIVU, 0, 0);
    chk("divu_start", 32'(md_start), 1);
    chk("divu_op", 32'(md_op), 3);
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1; opcode = R; funct = F_DIVU; stall_in = 1'b1; flush_in = 1'b0;
      #1;
      chk("divu_stall_out", 32'(stall_out), 1);
      tick();
      chk("divu_held_start", 32'(md_start), 0);
      chk("divu_held_valid", 32'(ex_valid), 1);
    end
    instr_valid = 1'b0; stall_in = 1'b0;
    n = 0;
    while (md_busy && n < 100) begin
      n++;
      tick();
    end
    chk("divu_starts", 32'(n_start - s0), 1);
    chk("divu_busy_cycles", 32'(n_busy - b0), 32);

    cyc(1, 6'h3F, 6'h00, 0, 0);
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_valid", 32'(ex_valid), 0);
    chk("ill_wb", 32'(ex_wb), 0);
    cyc(0, 6'h00, 6'h00, 0, 0);
    chk("ill_one_cycle", 32'(illegal), 0);
    cyc(1, 6'h3F, 6'h00, 0, 1);
    chk("ill_flush", 32'(illegal), 0);

    cyc(1, R, F_ADD, 0, 0);
    cyc(1, SW, 6'h00, 1, 1);
    chk("flush_stall_valid", 32'(ex_valid), 0);
    chk("flush_stall_m", 32'(ex_m), 0);

    b0 = n_busy;
    cyc(1, R, F_MULT, 0, 0);
    cyc(0, 6'h00, 6'h00, 0, 1);
    chk("flush_keeps_busy", 32'(md_busy), 1);
    flush_in = 1'b0;
    n = 0;
    while (md_busy && n < 20) begin
      n++;
      tick();
    end
    chk("flush_busy_cycles", 32'(n_busy - b0), 4);

    cyc(1, R, F_DIV, 0, 0);
    instr_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("div_mid_busy", 32'(md_busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 32'(dut_vec), 0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_release_busy", 32'(md_busy), 0);
    cyc(1, R, F_ADD, 0, 0);
    chk("post_rst_add_ex", 32'(ex_ex), 'h22);
    chk("post_rst_valid", 32'(ex_valid), 1);
    cyc(0, 6'h00, 6'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
